bmu_issue_ctrl: RTL and testbench
=================================

Name: bmu_issue_ctrl

Overview:
- Requester-side front end for the BMU execution unit.
- Accepts tagged ALU commands over a valid/ready interface and buffers them in a command FIFO.
- Encodes each opcode into the BMU one-hot control vector, drives the BMU operands and valid, and captures the registered result and error one cycle later.
- Returns in-order tagged responses over a valid/ready interface, with credit-limited issue so no BMU result is ever dropped.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TAG_W, 4, command/response tag width

Ports:
clk  in  1  clock
rst_l  in  1  async active-low reset
flush  in  1  sync flush of all queued/in-flight work
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  4  opcode
cmd_a  in  32  operand A
cmd_b  in  32  operand B
cmd_tag  in  TAG_W  command tag
bmu_valid_out  out  1  to BMU valid_in
bmu_a  out  32  to BMU a_in
bmu_b  out  32  to BMU b_in
bmu_ap  out  22  to BMU packed control struct
bmu_result  in  32  from BMU result_ff
bmu_error  in  1  from BMU error
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&&ready
rsp_data  out  32  result
rsp_error  out  1  error flag
rsp_tag  out  TAG_W  tag of the originating command
busy  out  1  any work queued, in flight or buffered

Behaviour:
- Reset: clk and rst_l, asynchronous, active-low.
- While in reset, all outputs are 0, including cmd_ready. FIFO, pending flag and response buffer are cleared.
- cmd_ready = !fifo_full. There is no same-cycle bypass, so a full FIFO refuses pushes even when it pops in the same cycle.

bmu_ap bit map (bit21 down to bit0):
- 21 csr_write, 20 csr_imm, 19 zbb, 18 zbp, 17 zba, 16 zbs, 15 land, 14 lxor.
- 13 sll, 12 sra, 11 rol, 10 bext, 9 sh3add, 8 add, 7 slt, 6 sub.
- 5 clz, 4 cpop, 3 siext_h, 2 min, 1 packu, 0 gorc.

Opcode encoding (exactly one bmu_ap bit is set):
- 0 ADD->add (0x000100), 1 SUB->sub (0x000040), 2 AND->land (0x008000), 3 XOR->lxor (0x004000).
- 4 SLL->sll (0x002000), 5 SRA->sra (0x001000), 6 SLT->slt (0x000080), 7 MIN->min (0x000004).
- Opcodes 8-15 are illegal. They are never sent to the BMU and are completed locally with data 0, error 1.

Issue:
- Credit = rsp_cnt - (rsp_valid&&rsp_ready) + pend.
- Issue in cycle N when the FIFO is non-empty, credit < 2 and flush=0.
- A legal issue drives bmu_valid_out=1 with bmu_a/bmu_b/bmu_ap from the FIFO head.
- An illegal-opcode issue keeps bmu_valid_out=0.
- In both cases the FIFO pops and pend is set, recording the tag and an illegal bit.
- When not issuing, bmu_valid_out=0 and bmu_a, bmu_b, bmu_ap are 0.

Capture:
- In cycle N+1, while pend=1, write {bmu_result, bmu_error, tag} into a 2-entry in-order response buffer.
- If the illegal bit is set, write {0, 1, tag} instead.
- pend clears unless a new issue occurs in the same cycle.

Response:
- rsp_* present the buffer head. rsp_valid = (rsp_cnt != 0).
- rsp_data, rsp_error and rsp_tag must stay stable while rsp_valid && !rsp_ready.

Timing:
- Latency from command acceptance at edge E to rsp_valid is 3 cycles (issue E+1, BMU result E+2, rsp_valid E+3).
- Throughput is 1 command per cycle while rsp_ready=1.

Flush:
- In the flush cycle: no issue, no push, cmd_ready=0, and any pending capture is discarded.
- Next cycle: FIFO, pend and response buffer are empty, rsp_valid=0.
- Flush overrides push, pop, issue and capture in the same cycle.

busy = !fifo_empty || pend || rsp_cnt != 0.

Reset during operation: all state is dropped immediately, and no stale response appears after rst_l deasserts.

Test Plan:
- ADD a=5, b=7, tag 3: bmu_ap=0x000100 and bmu_valid_out=1 one cycle after acceptance; rsp_data=12, rsp_error=0, rsp_tag=3, three cycles after acceptance.
- ADD 0x7FFFFFFF + 0x00000001: rsp_data=0x80000000, rsp_error=1. SUB 0x80000000 - 1: rsp_data=0x7FFFFFFF, rsp_error=1.
- Back-to-back SLL(1,4), SRA(0xF0000000,4), MIN(-3,2), tags 0-2, rsp_ready=1: one response per cycle, 0x10, 0xFF000000, 0xFFFFFFFD, in tag order.
- rsp_ready=0 while 8 commands are offered: 2 responses buffered, 4 held in the FIFO, cmd_ready drops after the 6th accept. Releasing rsp_ready returns tags 0-7 in order, none lost, responses stable while stalled.
- Sequence XOR, op 9 (illegal), AND: bmu_valid_out is never high for op 9; responses in order with the middle one data 0, error 1.
- flush with 3 commands queued and 1 in flight: the next cycle rsp_valid=0 and busy=0, and no stale response appears afterwards. Repeat with rst_l pulsed low mid-stream: all outputs 0 immediately.

Source files
------------

// File: rtl/bmu_issue_ctrl.sv
// BMU issue controller: buffers tagged ALU commands, issues them to the BMU
// with a one-hot control vector, and returns in-order tagged responses.
// Issue is credit-limited so every BMU result has a response-buffer slot.
module bmu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             bmu_valid_out,
  output logic [31:0]      bmu_a,
  output logic [31:0]      bmu_b,
  output logic [21:0]      bmu_ap,
  input  logic [31:0]      bmu_result,
  input  logic             bmu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [31:0]      data;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // One-hot control encodings for the eight legal opcodes
  function automatic logic [21:0] enc_ap(input logic [2:0] op);
    logic [21:0] ap;
    ap = '0;
    case (op)
      3'd0: ap = 22'h000100; // add
      3'd1: ap = 22'h000040; // sub
      3'd2: ap = 22'h008000; // land
      3'd3: ap = 22'h004000; // lxor
      3'd4: ap = 22'h002000; // sll
      3'd5: ap = 22'h001000; // sra
      3'd6: ap = 22'h000080; // slt
      3'd7: ap = 22'h000004; // min
      default: ap = '0;
    endcase
    return ap;
  endfunction

  cmd_t          fifo_q [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  cmd_t          cmd_in, head;
  logic          fifo_empty, fifo_full, push, issue, head_legal;

  rsp_t          rb_q [2];
  logic          rb_wp, rb_rp;
  logic [1:0]    rsp_cnt;
  rsp_t          cap_ent, rb_head;
  logic          cap, rsp_pop;
  logic [2:0]    credit;

  logic             pend, pend_ill;
  logic [TAG_W-1:0] pend_tag;

  assign cmd_in     = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign head       = fifo_q[rd_ptr[AW-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // rst_l gates ready so it reads 0 while reset is held
  assign cmd_ready  = rst_l && !fifo_full && !flush;
  assign push       = cmd_valid && cmd_ready;
  assign head_legal = !head.op[3];

  assign rsp_valid  = (rsp_cnt != 2'd0);
  assign rsp_pop    = rsp_valid && rsp_ready;
  // Slots that will be occupied next cycle; at most two may be owed
  assign credit     = {1'b0, rsp_cnt} + {2'b0, pend} - {2'b0, rsp_pop};
  assign issue      = !fifo_empty && (credit < 3'd2) && !flush;
  assign cap        = pend && !flush;

  assign bmu_valid_out = issue && head_legal;
  assign bmu_a         = bmu_valid_out ? head.a : '0;
  assign bmu_b         = bmu_valid_out ? head.b : '0;
  assign bmu_ap        = bmu_valid_out ? enc_ap(head.op[2:0]) : '0;

  assign rb_head   = rb_q[rb_rp];
  assign rsp_data  = rsp_valid ? rb_head.data : '0;
  assign rsp_error = rsp_valid ? rb_head.err  : 1'b0;
  assign rsp_tag   = rsp_valid ? rb_head.tag  : '0;
  assign busy      = !fifo_empty || pend || rsp_valid;

  // Command FIFO storage; push is already blocked by flush and full
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr[AW-1:0]] <= cmd_in;
  end

  // Command FIFO pointers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, issue};
    end
  end

  // In-flight marker: the BMU result for this issue lands next cycle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend     <= 1'b0;
      pend_ill <= 1'b0;
      pend_tag <= '0;
    end else begin
      pend     <= issue;
      pend_ill <= issue && !head_legal;
      pend_tag <= issue ? head.tag : '0;
    end
  end

  // Illegal opcodes complete locally with data 0, error 1
  always_comb begin
    cap_ent = '0;
    if (pend_ill) cap_ent = '{data: 32'd0, err: 1'b1, tag: pend_tag};
    else          cap_ent = '{data: bmu_result, err: bmu_error, tag: pend_tag};
  end

  // Response buffer storage
  always_ff @(posedge clk) begin
    if (cap) rb_q[rb_wp] <= cap_ent;
  end

  // Response buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rb_wp   <= 1'b0;
      rb_rp   <= 1'b0;
      rsp_cnt <= 2'd0;
    end else if (flush) begin
      rb_wp   <= 1'b0;
      rb_rp   <= 1'b0;
      rsp_cnt <= 2'd0;
    end else begin
      rb_wp   <= rb_wp ^ cap;
      rb_rp   <= rb_rp ^ rsp_pop;
      rsp_cnt <= rsp_cnt + {1'b0, cap} - {1'b0, rsp_pop};
    end
  end
endmodule

// File: tb/tb_bmu_issue_ctrl.sv
// Directed bench for bmu_issue_ctrl with a behavioural BMU and a response
// scoreboard fed at command acceptance and drained by a response monitor.
module tb_bmu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      d;
    logic             e;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic             clk = 1'b0, rst_l = 1'b0, flush = 1'b0;
  logic             cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0]       cmd_op = '0;
  logic [31:0]      cmd_a = '0, cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             cmd_ready, bmu_valid_out, rsp_valid, rsp_error, busy;
  logic [31:0]      bmu_a, bmu_b, rsp_data;
  logic [21:0]      bmu_ap;
  logic [31:0]      bmu_result;
  logic             bmu_error;
  logic [TAG_W-1:0] rsp_tag;

  int   n_checks = 0, n_errors = 0, n_pops = 0, n_bmu_iss = 0, cyc = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];

  bmu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .bmu_valid_out(bmu_valid_out), .bmu_a(bmu_a), .bmu_b(bmu_b), .bmu_ap(bmu_ap),
    .bmu_result(bmu_result), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference BMU: decodes the one-hot control, error = signed overflow
  function automatic logic [32:0] bmu_ref(input logic [21:0] ap, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e;
    r = '0; e = 1'b0;
    case (ap)
      22'h000100: begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
      22'h000040: begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
      22'h008000: r = a & b;
      22'h004000: r = a ^ b;
      22'h002000: r = a << b[4:0];
      22'h001000: r = $signed(a) >>> b[4:0];
      22'h000080: r = {31'd0, $signed(a) < $signed(b)};
      22'h000004: r = ($signed(a) < $signed(b)) ? a : b;
      default: begin r = 32'hDEADBEEF; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Behavioural BMU: registered result one cycle after valid
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bmu_result <= '0;
      bmu_error  <= 1'b0;
    end else if (bmu_valid_out) begin
      {bmu_error, bmu_result} <= bmu_ref(bmu_ap, bmu_a, bmu_b);
    end
  end

  // Response monitor: scoreboard compare on handshake, stability while stalled
  logic             prev_stall = 1'b0;
  logic [31:0]      prev_d;
  logic             prev_e;
  logic [TAG_W-1:0] prev_t;
  always @(negedge clk) begin
    exp_t x;
    if (bmu_valid_out) n_bmu_iss++;
    if (prev_stall && rsp_valid) begin
      chk("rsp_stable_data", rsp_data, prev_d);
      chk("rsp_stable_err", {31'd0, rsp_error}, {31'd0, prev_e});
      chk("rsp_stable_tag", {28'd0, rsp_tag}, {28'd0, prev_t});
    end
    prev_stall = rsp_valid && !rsp_ready && !flush && rst_l;
    prev_d = rsp_data; prev_e = rsp_error; prev_t = rsp_tag;
    if (rsp_valid && rsp_ready) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, x.t});
        chk("rsp_data", rsp_data, x.d);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, x.e});
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Offer one command; queue its expected response when it is accepted
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] ed, input logic ee);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (ok) exp_q.push_back('{d: ed, e: ee, t: tag});
    else chk("send_timeout", 32'd0, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({name, "_bmu_valid"}, {31'd0, bmu_valid_out}, 32'd0);
    chk({name, "_bmu_ab"}, bmu_a | bmu_b, 32'd0);
    chk({name, "_bmu_ap"}, {10'd0, bmu_ap}, 32'd0);
    chk({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, "_rsp_fields"}, rsp_data | {31'd0, rsp_error} | {28'd0, rsp_tag}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p0, i0;
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    step();
    rst_l = 1'b1; rsp_ready = 1'b1;

    // ADD 5+7 tag 3: issue one cycle, response three cycles after acceptance
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd5; cmd_b = 32'd7; cmd_tag = 4'd3;
    @(negedge clk);
    chk("add_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.push_back('{d: 32'd12, e: 1'b0, t: 4'd3});
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("add_bmu_valid", {31'd0, bmu_valid_out}, 32'd1);
    chk("add_bmu_ap", {10'd0, bmu_ap}, 32'h000100);
    chk("add_bmu_a", bmu_a, 32'd5);
    chk("add_bmu_b", bmu_b, 32'd7);
    chk("add_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("add_rsp_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("add_rsp_lat3", {31'd0, rsp_valid}, 32'd1);
    step();
    drain();

    // Signed overflow on ADD and SUB
    send(4'd0, 32'h7FFFFFFF, 32'h1, 4'd4, 32'h80000000, 1'b1);
    send(4'd1, 32'h80000000, 32'h1, 4'd5, 32'h7FFFFFFF, 1'b1);
    drain();

    // Back-to-back SLL, SRA, MIN: one response per cycle
    pop_cyc.delete();
    send(4'd4, 32'd1, 32'd4, 4'd0, 32'h10, 1'b0);
    send(4'd5, 32'hF0000000, 32'd4, 4'd1, 32'hFF000000, 1'b0);
    send(4'd7, 32'hFFFFFFFD, 32'd2, 4'd2, 32'hFFFFFFFD, 1'b0);
    drain();
    chk("b2b_count", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap01", pop_cyc[1] - pop_cyc[0], 32'd1);
      chk("b2b_gap12", pop_cyc[2] - pop_cyc[1], 32'd1);
    end

    // Stall: 2 buffered + 4 queued, then cmd_ready drops
    rsp_ready = 1'b0;
    p0 = n_pops;
    for (int i = 0; i < 6; i++) send(4'd0, i, 32'd100, 4'(i), i + 100, 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd6; cmd_b = 32'd100; cmd_tag = 4'd6;
    repeat (4) begin
      @(negedge clk);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stall_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    step();
    rsp_ready = 1'b1;
    send(4'd0, 32'd6, 32'd100, 4'd6, 32'd106, 1'b0);
    send(4'd0, 32'd7, 32'd100, 4'd7, 32'd107, 1'b0);
    drain();
    chk("stall_all_returned", n_pops - p0, 32'd8);

    // Illegal opcode in the middle never reaches the BMU
    i0 = n_bmu_iss;
    send(4'd3, 32'h0000F0F0, 32'h0000FF00, 4'd1, 32'h00000FF0, 1'b0);
    send(4'd9, 32'h12345678, 32'h1, 4'd2, 32'd0, 1'b1);
    send(4'd2, 32'h0000F0F0, 32'h0000FF00, 4'd3, 32'h0000F000, 1'b0);
    drain();
    chk("illegal_bmu_issues", n_bmu_iss - i0, 32'd2);

    // Flush with 3 queued, 1 in flight, 1 buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(4'd0, i, 32'd1, 4'(i), i + 1, 1'b0);
    rsp_ready = 1'b1;
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("flush_no_issue", {31'd0, bmu_valid_out}, 32'd0);
    step();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("flush_quiet", {31'd0, rsp_valid | busy}, 32'd0);
    end
    step();
    send(4'd0, 32'd20, 32'd22, 4'd9, 32'd42, 1'b0);
    drain();

    // Reset pulsed mid-stream: outputs drop immediately, nothing stale after
    rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) send(4'd1, 32'd50, i, 4'(i), 32'd50 - i, 1'b0);
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1 chk_all_zero("midrst");
    exp_q.delete();
    rsp_ready = 1'b1;
    repeat (2) step();
    rst_l = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_quiet", {31'd0, rsp_valid | busy}, 32'd0);
    end
    step();
    send(4'd6, 32'hFFFFFFFF, 32'd1, 4'd10, 32'd1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
